// File: rtl/seg_capture.sv
// seg_capture: recovers two multiplexed 7-seg digits
// from sampled anode/segment lines into coherent frames.
module seg_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 1024
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic [3:0] anode,
  input  logic [7:0] ledx,
  input  logic       clrErr,
  output logic [7:0] digit1,
  output logic [7:0] digit2,
  output logic       valid,
  output logic       frameStrobe,
  output logic       illegal,
  output logic       stale
);

  localparam logic [7:0]  SMAX  = 8'(STABLE_CYCLES);
  localparam logic [15:0] TLIM  = 16'(TIMEOUT - 1);
  localparam logic [3:0]  A_S1  = 4'b1011;
  localparam logic [3:0]  A_S2  = 4'b0111;
  localparam logic [3:0]  A_BLK = 4'b1111;

  typedef enum logic {
    SEEK  = 1'b0,
    HAVE1 = 1'b1
  } state_t;

  state_t      state;
  state_t      stateNxt;
  logic [11:0] sync1;
  logic [11:0] sync2;
  logic [11:0] prevW;
  logic [1:0]  fill;
  logic [7:0]  cnt;
  logic        capD;
  logic        capV;
  logic [3:0]  capAn;
  logic [7:0]  capLed;
  logic [7:0]  pending;
  logic [15:0] tmr;
  logic        tmoHit;
  logic        tmo;
  logic        isS1;
  logic        isS2;
  logic        isBad;
  logic        loadPend;
  logic        frameDone;

  // anode and segments cross into clk together as one word;
  // fill marks when sync2 holds real samples, not reset zeros
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sync1 <= '0;
      sync2 <= '0;
      fill  <= '0;
    end else begin
      sync1 <= {anode, ledx};
      sync2 <= sync1;
      fill  <= {fill[0], 1'b1};
    end
  end

  // run length of identical words, saturating so a held
  // word captures exactly once
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      prevW <= '0;
      cnt   <= '0;
    end else begin
      prevW <= sync2;
      if (!fill[1])
        cnt <= '0;
      else if (cnt == 8'd0 || sync2 != prevW)
        cnt <= 8'd1;
      else if (cnt != SMAX)
        cnt <= cnt + 8'd1;
    end
  end

  assign capD = fill[1] && (sync2 == prevW)
             && (cnt == SMAX - 8'd1);

  // register the captured word for the decode stage
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      capV   <= 1'b0;
      capAn  <= '0;
      capLed <= '0;
    end else begin
      capV <= capD;
      if (capD) {capAn, capLed} <= sync2;
    end
  end

  // classify the captured anode code
  always_comb begin
    isS1  = 1'b0;
    isS2  = 1'b0;
    isBad = 1'b0;
    if (capV) begin
      unique case (1'b1)
        capAn == A_S1:  isS1  = 1'b1;
        capAn == A_S2:  isS2  = 1'b1;
        capAn == A_BLK: ;
        default:        isBad = 1'b1;
      endcase
    end
  end

  // cycles since any capture; a capture beats a timeout
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)
      tmr <= '0;
    else if (capV)
      tmr <= '0;
    else if (!tmoHit)
      tmr <= tmr + 16'd1;
  end

  assign tmoHit = (tmr >= TLIM);
  assign tmo    = tmoHit && !capV;

  // FSM state register
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= SEEK;
    else       state <= stateNxt;
  end

  // FSM next state
  always_comb begin
    stateNxt = state;
    unique case (state)
      SEEK:  if (isS1) stateNxt = HAVE1;
      HAVE1: if (tmo || isS2) stateNxt = SEEK;
    endcase
  end

  // FSM outputs: which registers load this cycle
  always_comb begin
    loadPend  = isS1;
    frameDone = (state == HAVE1) && isS2;
  end

  // frame registers; both digits always load together
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      pending     <= '0;
      digit1      <= '0;
      digit2      <= '0;
      valid       <= 1'b0;
      frameStrobe <= 1'b0;
      stale       <= 1'b0;
    end else begin
      frameStrobe <= frameDone;
      if (loadPend) pending <= capLed;
      if (frameDone) begin
        digit1 <= pending;
        digit2 <= capLed;
        valid  <= 1'b1;
        stale  <= 1'b0;
      end else if (tmo) begin
        valid <= 1'b0;
        stale <= 1'b1;
      end
    end
  end

  // sticky error; a new illegal code beats the clear
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)       illegal <= 1'b0;
    else if (isBad)  illegal <= 1'b1;
    else if (clrErr) illegal <= 1'b0;
  end

endmodule

// File: tb/tb_seg_capture.sv
// tb_seg_capture: directed checks of seg_capture
// at default STABLE_CYCLES=4, TIMEOUT=1024.
module tb_seg_capture;

  logic       clk;
  logic       rstN;
  logic [3:0] anode;
  logic [7:0] ledx;
  logic       clrErr;
  logic [7:0] digit1;
  logic [7:0] digit2;
  logic       valid;
  logic       frameStrobe;
  logic       illegal;
  logic       stale;

  int checks = 0;
  int errors = 0;

  seg_capture dut (
    .clk(clk),
    .rstN(rstN),
    .anode(anode),
    .ledx(ledx),
    .clrErr(clrErr),
    .digit1(digit1),
    .digit2(digit2),
    .valid(valid),
    .frameStrobe(frameStrobe),
    .illegal(illegal),
    .stale(stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] a,
                       input logic [7:0] l);
    anode = a;
    ledx  = l;
  endtask

  task automatic test_reset;
    tick(3);
    checks++;
    if ({digit1, digit2} !== 16'h0000) begin
      errors++;
      $display("FAIL rst_digits got %h want 0000",
               {digit1, digit2});
    end
    checks++;
    if ({valid, frameStrobe, illegal, stale} !== 4'b0) begin
      errors++;
      $display("FAIL rst_flags got %b want 0000",
               {valid, frameStrobe, illegal, stale});
    end
    rstN = 1'b1;
    tick(12);
    checks++;
    if ({valid, frameStrobe, illegal} !== 3'b0) begin
      errors++;
      $display("FAIL blank_ignored got %b want 000",
               {valid, frameStrobe, illegal});
    end
  endtask

  task automatic test_frame;
    logic e;
    drive(4'b1011, 8'hC0);
    tick(10);
    drive(4'b0111, 8'hF9);
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      e = (k == 7);
      checks++;
      if (frameStrobe !== e) begin
        errors++;
        $display("FAIL frame_strobe_e%0d got %b want %b",
                 k, frameStrobe, e);
      end
      e = (k >= 7);
      checks++;
      if (valid !== e) begin
        errors++;
        $display("FAIL frame_valid_e%0d got %b want %b",
                 k, valid, e);
      end
    end
    checks++;
    if ({digit1, digit2} !== 16'hC0F9) begin
      errors++;
      $display("FAIL frame_digits got %h want C0F9",
               {digit1, digit2});
    end
  endtask

  task automatic test_glitch;
    int n;
    n = 0;
    drive(4'b1011, 8'hC0);
    tick(3);
    drive(4'b0111, 8'hA1);
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (frameStrobe) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL glitch_nostrobe got %0d want 0", n);
    end
    drive(4'b1011, 8'hC0);
    tick(10);
    drive(4'b0111, 8'hA1);
    for (int k = 0; k < 12; k++) begin
      tick(1);
      if (frameStrobe) n++;
    end
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL glitch_recover got %0d want 1", n);
    end
    checks++;
    if ({digit1, digit2} !== 16'hC0A1) begin
      errors++;
      $display("FAIL glitch_digits got %h want C0A1",
               {digit1, digit2});
    end
  endtask

  task automatic test_order;
    int n;
    n = 0;
    drive(4'b0111, 8'hA4);
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (frameStrobe) n++;
    end
    drive(4'b1011, 8'hB0);
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (frameStrobe) n++;
    end
    drive(4'b0111, 8'h99);
    for (int k = 0; k < 12; k++) begin
      tick(1);
      if (frameStrobe) n++;
    end
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL order_strobes got %0d want 1", n);
    end
    checks++;
    if ({digit1, digit2} !== 16'hB099) begin
      errors++;
      $display("FAIL order_digits got %h want B099",
               {digit1, digit2});
    end
  endtask

  task automatic test_illegal;
    drive(4'b0000, 8'h55);
    tick(6);
    checks++;
    if (illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_early got %b want 0", illegal);
    end
    drive(4'b1111, 8'hFF);
    tick(1);
    checks++;
    if (illegal !== 1'b1) begin
      errors++;
      $display("FAIL illegal_set got %b want 1", illegal);
    end
    tick(10);
    checks++;
    if (illegal !== 1'b1) begin
      errors++;
      $display("FAIL illegal_sticky got %b want 1", illegal);
    end
    clrErr = 1'b1;
    tick(1);
    clrErr = 1'b0;
    checks++;
    if (illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_clr got %b want 0", illegal);
    end
    drive(4'b0000, 8'h66);
    tick(6);
    clrErr = 1'b1;
    tick(1);
    clrErr = 1'b0;
    checks++;
    if (illegal !== 1'b1) begin
      errors++;
      $display("FAIL illegal_vs_clr got %b want 1", illegal);
    end
    clrErr = 1'b1;
    tick(1);
    clrErr = 1'b0;
    drive(4'b1111, 8'hFF);
    tick(10);
    checks++;
    if (illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_clr2 got %b want 0", illegal);
    end
  endtask

  task automatic test_timeout;
    int n;
    bit seen;
    seen = 0;
    drive(4'b1011, 8'hC3);
    tick(10);
    drive(4'b0111, 8'hF8);
    for (int k = 0; k < 12 && !seen; k++) begin
      tick(1);
      if (frameStrobe) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL tmo_frame got no strobe want strobe");
    end
    drive(4'b1011, 8'hC3);
    for (int k = 1; k <= 1100; k++) begin
      tick(1);
      if (k == 1030) begin
        checks++;
        if ({stale, valid} !== 2'b01) begin
          errors++;
          $display("FAIL tmo_before got %b want 01",
                   {stale, valid});
        end
      end
      if (k == 1031 || k == 1100) begin
        checks++;
        if ({stale, valid} !== 2'b10) begin
          errors++;
          $display("FAIL tmo_at_%0d got %b want 10",
                   k, {stale, valid});
        end
        checks++;
        if ({digit1, digit2} !== 16'hC3F8) begin
          errors++;
          $display("FAIL tmo_digits got %h want C3F8",
                   {digit1, digit2});
        end
      end
    end
    n = 0;
    drive(4'b0111, 8'hB5);
    for (int k = 0; k < 12; k++) begin
      tick(1);
      if (frameStrobe) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL tmo_pend_drop got %0d want 0", n);
    end
    drive(4'b1011, 8'h92);
    tick(10);
    drive(4'b0111, 8'h82);
    for (int k = 0; k < 12; k++) begin
      tick(1);
      if (frameStrobe) n++;
    end
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL tmo_new_frame got %0d want 1", n);
    end
    checks++;
    if ({stale, valid, digit1, digit2} !== 18'h19282) begin
      errors++;
      $display("FAIL tmo_recover got %h want 19282",
               {stale, valid, digit1, digit2});
    end
  endtask

  task automatic test_reset_mid;
    int n;
    n = 0;
    drive(4'b1011, 8'hA8);
    tick(10);
    #2 rstN = 1'b0;
    #1;
    checks++;
    if ({digit1, digit2, valid, frameStrobe,
         illegal, stale} !== 20'h0) begin
      errors++;
      $display("FAIL async_rst got %h want 00000",
               {digit1, digit2, valid, frameStrobe,
                illegal, stale});
    end
    tick(2);
    rstN = 1'b1;
    drive(4'b0111, 8'hA9);
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (frameStrobe) n++;
    end
    checks++;
    if (n != 0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_pend_drop got n=%0d v=%b want 0 0",
               n, valid);
    end
    drive(4'b1011, 8'hA8);
    tick(10);
    drive(4'b0111, 8'hA9);
    for (int k = 0; k < 12; k++) begin
      tick(1);
      if (frameStrobe) n++;
    end
    checks++;
    if (n != 1 || {digit1, digit2} !== 16'hA8A9) begin
      errors++;
      $display("FAIL rst_recover got n=%0d d=%h want 1 A8A9",
               n, {digit1, digit2});
    end
  endtask

  initial begin
    rstN   = 1'b0;
    clrErr = 1'b0;
    drive(4'b1111, 8'hFF);
    test_reset;
    test_frame;
    test_glitch;
    test_order;
    test_illegal;
    test_timeout;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_capture.md
SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4: consecutive identical synchronized samples (range 2..255) required before a digit is captured.
REQ-002 SHALL have parameter TIMEOUT, default 1024: clk cycles without any capture before the stale condition is raised (range 16..65535).
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge; the design uses one clock.
REQ-004 SHALL have port rstN  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port anode  input  4  multiplexed display digit enables, active-low; asynchronous to clk.
REQ-006 SHALL have port ledx  input  8  multiplexed segment lines; asynchronous to clk.
REQ-007 SHALL have port clrErr  input  1  synchronous clear of illegal.
REQ-008 SHALL have port digit1  output  8  recovered segments for slot 1 (anode 4'b1011).
REQ-009 SHALL have port digit2  output  8  recovered segments for slot 2 (anode 4'b0111).
REQ-010 SHALL have port valid  output  1  digit1/digit2 hold a coherent completed frame.
REQ-011 SHALL have port frameStrobe  output  1  one-cycle pulse on each frame completion.
REQ-012 SHALL have port illegal  output  1  sticky flag: an unsupported anode code was captured.
REQ-013 SHALL have port stale  output  1  no capture within TIMEOUT cycles.

Function
REQ-014 SHALL pass anode and ledx together, as one 12-bit word, through a two-flop synchronizer before any use.
REQ-015 SHALL compare each synchronized word with the previous one; equal -> stability count increments, saturating at STABLE_CYCLES; different -> count reloads to 1.
REQ-016 SHALL issue exactly one capture per stable period, on the edge where the count first reaches STABLE_CYCLES; a word held indefinitely never re-captures.
REQ-017 SHALL decode captured anode: 4'b1011 -> slot-1 capture; 4'b0111 -> slot-2 capture; 4'b1111 -> blank, ignored, no error; any other code -> illegal set to 1, capture otherwise ignored.
REQ-018 SHALL implement a two-state FSM: SEEK (no pending slot-1) and HAVE1 (pending slot-1 held in an internal register).
REQ-019 In SEEK, slot-1 capture SHALL store pending and go to HAVE1; slot-2 capture SHALL be ignored.
REQ-020 In HAVE1, slot-1 capture SHALL overwrite pending and stay in HAVE1.
REQ-021 In HAVE1, slot-2 capture SHALL, on the next edge: digit1 <= pending, digit2 <= captured ledx, valid <= 1, frameStrobe <= 1 for one cycle, stale <= 0, FSM -> SEEK.
REQ-022 digit1 and digit2 SHALL only ever change together, so outputs never mix frames.
REQ-023 Latency from a held input word to frameStrobe SHALL be STABLE_CYCLES+3 rising edges (7 at default).
REQ-024 SHALL count cycles since the last capture of any slot, including blank and illegal; the count resets on every capture.
REQ-025 When the count reaches TIMEOUT, the block SHALL set stale=1 and valid=0, discard pending, and force SEEK; digit1/digit2 retain their values.
REQ-026 If timeout and a capture coincide on the same edge, the capture SHALL win and the counter reset.
REQ-027 clrErr SHALL clear illegal; if an illegal capture occurs in the same cycle, illegal SHALL remain 1.

Reset
REQ-028 rstN low SHALL immediately force: digit1=8'h00, digit2=8'h00, valid=0, frameStrobe=0, illegal=0, stale=0, FSM=SEEK, synchronizer/stability/timeout counters cleared.
REQ-029 Reset asserted mid-frame SHALL discard pending slot-1; after release, a full slot-1 then slot-2 sequence SHALL be required before valid.

Verification
REQ-030 Frame: anode=1011/ledx=8'hC0 for 10 cycles, then anode=0111/ledx=8'hF9 held -> frameStrobe one cycle, 7 edges after the 0111 word is applied; digit1=C0, digit2=F9, valid=1.
REQ-031 Glitch: anode=1011 held 3 cycles, then 0111 -> no slot-1 capture; no frameStrobe until a full 1011 period precedes 0111.
REQ-032 Order: 0111/8'hA4 then 1011/8'hB0 then 0111/8'h99 -> single frameStrobe with digit1=B0, digit2=99.
REQ-033 Illegal: anode=0000 held 6 cycles -> illegal=1 and stays 1; pulse clrErr -> illegal=0 next edge.
REQ-034 Timeout: complete one frame, then freeze inputs at 1011 for 1100 cycles -> stale=1, valid=0 at cycle TIMEOUT after last capture; digit values unchanged; next full frame -> stale=0, valid=1.
REQ-035 Reset: rstN low while FSM in HAVE1 -> all outputs at reset values asynchronously; after release, a 0111-only stimulus produces no frameStrobe.
